// File: rtl/result_fifo128_fwft_if.sv
// Handshake bundle for the 128-bit FWFT result FIFO.
// almost_full exists only when RESULT_FIFO_WATERMARK_EN is defined.
interface result_fifo128_fwft_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
);
    logic                     push;
    logic [DATA_W-1:0]        push_data;
    logic                     fifo_pop;
    logic                     clear_overflow;
    logic [DATA_W-1:0]        fifo_out;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [$clog2(DEPTH):0]   fill_count;
    logic                     overflow;
`ifdef RESULT_FIFO_WATERMARK_EN
    logic                     almost_full;
`endif

    modport master (
`ifdef RESULT_FIFO_WATERMARK_EN
        input  almost_full,
`endif
        output push,
        output push_data,
        output fifo_pop,
        output clear_overflow,
        input  fifo_out,
        input  fifo_empty,
        input  fifo_full,
        input  fill_count,
        input  overflow
    );

    modport slave (
`ifdef RESULT_FIFO_WATERMARK_EN
        output almost_full,
`endif
        input  push,
        input  push_data,
        input  fifo_pop,
        input  clear_overflow,
        output fifo_out,
        output fifo_empty,
        output fifo_full,
        output fill_count,
        output overflow
    );
endinterface

// File: rtl/result_fifo128_fwft.sv
// First-word-fall-through result FIFO with full-drop and sticky overflow.
// Optional registered almost_full under RESULT_FIFO_WATERMARK_EN.
module result_fifo128_fwft #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    result_fifo128_fwft_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    logic empty, full;
    logic push_ok, pop_ok, drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_C);
    assign pop_ok  = bus.fifo_pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);
    assign drop    = bus.push & ~push_ok;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // a drop in the same cycle as a clear must stay visible
        if (drop)
            overflow_d = 1'b1;
        else if (bus.clear_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem_q[wr_ptr_q] <= bus.push_data;
    end

    assign bus.fifo_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.fill_count = count_q;
    assign bus.overflow   = overflow_q;

`ifdef RESULT_FIFO_WATERMARK_EN
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    logic af_q, af_d;

    assign af_d = (count_d >= AF_C);

    always_ff @(posedge clk) begin
        if (reset) af_q <= 1'b0;
        else       af_q <= af_d;
    end

    assign bus.almost_full = af_q;
`endif
endmodule
